// File: rtl/vga_sync_rx_if.sv
// vga_sync_rx_if: groups the sampled video timing inputs and the recovered
// timing outputs of vga_sync_rx.
//   master : video source / capture side (drives timing, consumes coordinates)
//   slave  : vga_sync_rx itself
// Signals:
//   i_pix_stb, i_hs, i_vs, i_blanking : incoming timing (hs/vs active low)
//   o_x, o_y, o_de                    : recovered coordinates and data enable
//   o_locked, o_frame_start, o_err    : lock status and one-clock pulses
//   o_line_len, o_frame_lines         : last measured line / frame length
interface vga_sync_rx_if;
   logic       i_pix_stb;
   logic       i_hs;
   logic       i_vs;
   logic       i_blanking;
   logic [9:0] o_x;
   logic [8:0] o_y;
   logic       o_de;
   logic       o_locked;
   logic       o_frame_start;
   logic       o_err;
   logic [9:0] o_line_len;
   logic [9:0] o_frame_lines;

   modport master (
      output i_pix_stb, i_hs, i_vs, i_blanking,
      input  o_x, o_y, o_de, o_locked, o_frame_start, o_err, o_line_len, o_frame_lines
   );

   modport slave (
      input  i_pix_stb, i_hs, i_vs, i_blanking,
      output o_x, o_y, o_de, o_locked, o_frame_start, o_err, o_line_len, o_frame_lines
   );
endinterface

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: receive-side VGA timing recovery. Samples hsync/vsync/blanking
// on pixel strobes, measures line period and lines per frame, locks onto a
// stable timing and regenerates pixel coordinates plus data enable.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : vga_sync_rx_if.slave (timing inputs, recovered outputs)
module vga_sync_rx #(
   parameter int unsigned P_LINE_MIN  = 700,
   parameter int unsigned P_LINE_MAX  = 900,
   parameter int unsigned P_LINES_MIN = 500,
   parameter int unsigned P_LINES_MAX = 600
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   vga_sync_rx_if.slave bus
);

   localparam logic [9:0] LineMin  = 10'(P_LINE_MIN);
   localparam logic [9:0] LineMax  = 10'(P_LINE_MAX);
   localparam logic [9:0] LinesMin = 10'(P_LINES_MIN);
   localparam logic [9:0] LinesMax = 10'(P_LINES_MAX);
   localparam logic [9:0] CntMax   = 10'd1023;

   typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

   state_e     state_q;
   logic       hs_prev_q, vs_prev_q;
   logic [9:0] h_cnt_q, v_cnt_q, x_cnt_q;
   logic [8:0] y_cnt_q;
   logic       active_seen_q;
   logic       unstable_q, prev_valid_q;
   logic [9:0] ref_line_q, ref_lines_q;
   logic [9:0] x_q, line_len_q, frame_lines_q;
   logic       de_q, locked_q, frame_start_q, err_q;

   logic       hs_fall, vs_fall;
   logic [9:0] period, v_cnt_upd, line_len_upd, x_inc;
   logic [8:0] y_inc;
   logic       unstable_upd, lock_ok, violation;

   always_comb begin
      hs_fall      = hs_prev_q & ~bus.i_hs;
      vs_fall      = vs_prev_q & ~bus.i_vs;
      // Period of the line ending on this strobe is h_cnt + 1, saturated.
      period       = (h_cnt_q == CntMax) ? CntMax : h_cnt_q + 10'd1;
      // Line count as seen after any hs_fall on this same strobe.
      v_cnt_upd    = v_cnt_q;
      if (hs_fall && v_cnt_q != CntMax) v_cnt_upd = v_cnt_q + 10'd1;
      line_len_upd = hs_fall ? period : line_len_q;
      x_inc        = (x_cnt_q == CntMax) ? CntMax : x_cnt_q + 10'd1;
      y_inc        = (y_cnt_q == 9'd511) ? 9'd511 : y_cnt_q + 9'd1;
      // o_line_len doubles as the previous period for the stability check.
      unstable_upd = unstable_q | (hs_fall & prev_valid_q & (period != line_len_q));
      lock_ok      = ~unstable_upd &
                     (line_len_upd >= LineMin) && (line_len_upd <= LineMax) &&
                     (v_cnt_upd >= LinesMin) && (v_cnt_upd <= LinesMax);
      violation    = (hs_fall && period != ref_line_q) ||
                     (vs_fall && v_cnt_upd != ref_lines_q) ||
                     (!hs_fall && period == CntMax);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= StSearch;
         hs_prev_q     <= 1'b1;
         vs_prev_q     <= 1'b1;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         x_cnt_q       <= '0;
         y_cnt_q       <= '0;
         active_seen_q <= 1'b0;
         unstable_q    <= 1'b0;
         prev_valid_q  <= 1'b0;
         ref_line_q    <= '0;
         ref_lines_q   <= '0;
         x_q           <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         de_q          <= 1'b0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         err_q         <= 1'b0;
         if (bus.i_pix_stb) begin
            hs_prev_q <= bus.i_hs;
            vs_prev_q <= bus.i_vs;

            // Line / frame measurement
            h_cnt_q <= hs_fall ? 10'd0 : period;
            if (hs_fall) line_len_q <= period;
            v_cnt_q <= vs_fall ? 10'd0 : v_cnt_upd;
            if (vs_fall) frame_lines_q <= v_cnt_upd;

            // Coordinates
            if (!bus.i_blanking) begin
               x_q           <= x_cnt_q;
               x_cnt_q       <= x_inc;
               de_q          <= locked_q;
               active_seen_q <= 1'b1;
            end else begin
               x_cnt_q <= '0;
               de_q    <= 1'b0;
            end
            // Rows advance only after a line that carried active pixels.
            if (hs_fall && active_seen_q) begin
               y_cnt_q       <= y_inc;
               active_seen_q <= 1'b0;
            end
            if (vs_fall) y_cnt_q <= '0;

            // Lock FSM
            unique case (state_q)
               StSearch: begin
                  if (vs_fall) begin
                     state_q      <= StAcquire;
                     unstable_q   <= 1'b0;
                     prev_valid_q <= 1'b0;
                  end
               end
               StAcquire: begin
                  unstable_q <= unstable_upd;
                  if (hs_fall) prev_valid_q <= 1'b1;
                  if (vs_fall) begin
                     if (lock_ok) begin
                        ref_line_q  <= line_len_upd;
                        ref_lines_q <= v_cnt_upd;
                        state_q     <= StLocked;
                        locked_q    <= 1'b1;
                     end else begin
                        unstable_q <= 1'b0;
                     end
                  end
               end
               StLocked: begin
                  if (violation) begin
                     err_q        <= 1'b1;
                     locked_q     <= 1'b0;
                     de_q         <= 1'b0;
                     state_q      <= StAcquire;
                     unstable_q   <= 1'b0;
                     prev_valid_q <= 1'b0;
                  end else if (vs_fall) begin
                     frame_start_q <= 1'b1;
                  end
               end
               default: state_q <= StSearch;
            endcase
         end
      end
   end

   assign bus.o_x           = x_q;
   assign bus.o_y           = y_cnt_q;
   assign bus.o_de          = de_q;
   assign bus.o_locked      = locked_q;
   assign bus.o_frame_start = frame_start_q;
   assign bus.o_err         = err_q;
   assign bus.o_line_len    = line_len_q;
   assign bus.o_frame_lines = frame_lines_q;

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive-side companion to the team's VGA timing generator.
- Samples incoming hsync/vsync/blanking on pixel strobes, measures line length and lines per frame, and locks onto a stable timing.
- Regenerates pixel coordinates and data-enable for downstream capture logic, e.g. frame grabber and on-chip video checker.

Parameters:
- P_LINE_MIN, 700: minimum accepted strobes per line.
- P_LINE_MAX, 900: maximum accepted strobes per line.
- P_LINES_MIN, 500: minimum accepted lines per frame.
- P_LINES_MAX, 600: maximum accepted lines per frame.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_stb  in  1  pixel strobe; all sampling and counting occurs only on cycles where this is 1
- i_hs  in  1  horizontal sync, active low
- i_vs  in  1  vertical sync, active low
- i_blanking  in  1  1 = blanking interval
- o_x  out  10  recovered active-pixel column
- o_y  out  9  recovered active-line row
- o_de  out  1  data enable, active pixel while locked
- o_locked  out  1  timing locked
- o_frame_start  out  1  one-clock pulse at vsync falling edge while locked
- o_err  out  1  one-clock pulse on timing violation while locked
- o_line_len  out  10  last measured line period, in strobes
- o_frame_lines  out  10  last measured frame length, in lines

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active low.
- Reset values: all outputs 0; state SEARCH; hs_prev = 1; vs_prev = 1; all counters 0.
- Edge detection: on a strobe, hs_fall = hs_prev & ~i_hs and vs_fall = vs_prev & ~i_vs; hs_prev and vs_prev update on the same strobe.
- h_cnt:
  - Increments each strobe, saturating at 1023.
  - On hs_fall: o_line_len <= h_cnt + 1 (saturating at 1023), then h_cnt <= 0.
- v_cnt:
  - Increments on each hs_fall.
  - On vs_fall: o_frame_lines <= v_cnt, plus 1 if hs_fall occurs on the same strobe; then v_cnt <= 0.
- Coordinates (registered, 1-clock latency after the strobe; outputs hold between strobes):
  - i_blanking = 0: o_x <= x_cnt; x_cnt <= x_cnt + 1 (saturating at 1023); o_de <= o_locked; active_seen <= 1.
  - i_blanking = 1: x_cnt <= 0; o_de <= 0; o_x holds.
  - On hs_fall with active_seen = 1: y_cnt <= y_cnt + 1 (saturating at 511); active_seen <= 0.
  - On vs_fall: y_cnt <= 0. o_y = y_cnt.
- FSM:
  - SEARCH: on vs_fall -> ACQUIRE; clear the stability flag (unstable <= 0) and prev_valid <= 0.
  - ACQUIRE, on each hs_fall: if prev_valid and the new period differs from the previous period, set unstable <= 1; then prev_valid <= 1.
  - ACQUIRE, on vs_fall: if unstable = 0, the line period is within [P_LINE_MIN, P_LINE_MAX], and the frame lines are within [P_LINES_MIN, P_LINES_MAX]:
    - store ref_line and ref_lines;
    - go to LOCKED;
    - o_locked <= 1 on the same clock.
    Otherwise stay in ACQUIRE and clear unstable.
  - LOCKED: a violation is any of the following:
    - an hs_fall whose period differs from ref_line;
    - a vs_fall whose frame lines differ from ref_lines;
    - h_cnt reaching 1023.
  - LOCKED, on a violation: o_err pulses for 1 clock; o_locked <= 0; state -> ACQUIRE with unstable and prev_valid cleared; o_de is forced to 0 from the next clock.
  - o_frame_start pulses only when vs_fall is detected in LOCKED with no violation on that strobe.
- Simultaneous hs_fall and vs_fall: hs_fall processing (period check, v_cnt, y_cnt) is applied first; the vs_fall check then uses the updated line count.
- Strobe-less cycles: no state changes; pulse outputs return to 0.
- Reset asserted mid-frame: immediately returns to reset values. Lock requires one full SEARCH-to-vs plus one clean frame.

Test Plan:
- Nominal timing (801 strobes/line: hs low strobes 16-111, blanking strobes 0-159; 525 lines; vs low lines 491-492; i_pix_stb every 4th clock) -> o_line_len = 801, o_frame_lines = 525; o_locked = 1 at the second vs_fall; o_frame_start each frame thereafter.
- While locked -> o_x runs 0..640 across each active line with o_de = 1; o_y runs 0..479; o_de = 0 in all blanking.
- Locked, one line shortened to 800 strobes -> o_err single pulse at that hs_fall; o_locked = 0 next clock; relock after the next clean full frame.
- Line period 1200 strobes -> h_cnt saturates at 1023; no lock; o_line_len = 1023.
- Frame with 450 lines -> stays in ACQUIRE; o_locked remains 0.
- Assert i_rst_n low mid-line while locked -> all outputs 0 asynchronously; after release, lock only after SEARCH -> ACQUIRE -> one clean frame.
